// File: rtl/sdc_clk_gen_if.sv
// Burst request / SCK output bundle shared between sdc_clk_gen and its
// shift-register and command FSM clients.
interface sdc_clk_gen_if #(
   parameter int NB_W = 7
) ();
   logic            i_start;
   logic [NB_W-1:0] i_nbits;
   logic            i_fast;
   logic            i_cpol;
   logic            o_sck;
   logic            o_lead_stb;
   logic            o_trail_stb;
   logic            o_busy;
   logic            o_done;

   modport master (
      output i_start, i_nbits, i_fast, i_cpol,
      input  o_sck, o_lead_stb, o_trail_stb, o_busy, o_done
   );

   modport slave (
      input  i_start, i_nbits, i_fast, i_cpol,
      output o_sck, o_lead_stb, o_trail_stb, o_busy, o_done
   );
endinterface

// File: rtl/sdc_clk_gen.sv
// Burst SCK generator for the SPI/SD-card link: slow/fast rate, selectable
// idle polarity, per-burst edge strobes and a busy/done handshake after a gap.
module sdc_clk_gen #(
   parameter int DIV_W    = 10,
   parameter int DIV_SLOW = 135,
   parameter int DIV_FAST = 14,
   parameter int GAP_CYC  = 540,
   parameter int NB_W     = 7
) (
   input  logic          i_clk_27_MHz,
   input  logic          i_rst_n,
   sdc_clk_gen_if.slave  bus
);

   localparam logic [DIV_W-1:0] SLOW_M1 = DIV_W'(DIV_SLOW - 1);
   localparam logic [DIV_W-1:0] FAST_M1 = DIV_W'(DIV_FAST - 1);
   localparam logic [DIV_W-1:0] GAP_V   = DIV_W'(GAP_CYC);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  half_m1;
   logic [NB_W-1:0]   nbits_q;
   logic              cpol_q;
   logic [DIV_W-1:0]  cnt;
   logic [DIV_W-1:0]  gcnt;
   logic [NB_W:0]     edges;
   logic [NB_W:0]     edges_nx;
   logic              sck;
   logic              lead_stb;
   logic              trail_stb;
   logic              busy;
   logic              done;

   assign edges_nx = edges + 1'b1;

   always_ff @(posedge i_clk_27_MHz or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         half_m1   <= '0;
         nbits_q   <= '0;
         cpol_q    <= 1'b0;
         cnt       <= '0;
         gcnt      <= '0;
         edges     <= '0;
         sck       <= 1'b0;
         lead_stb  <= 1'b0;
         trail_stb <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         lead_stb  <= 1'b0;
         trail_stb <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               sck <= bus.i_cpol;
               if (bus.i_start && (bus.i_nbits != '0)) begin
                  half_m1 <= bus.i_fast ? FAST_M1 : SLOW_M1;
                  nbits_q <= bus.i_nbits;
                  cpol_q  <= bus.i_cpol;
                  cnt     <= '0;
                  edges   <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (cnt == half_m1) begin
                  cnt   <= '0;
                  sck   <= ~sck;
                  edges <= edges_nx;
                  // even edge count before this toggle means sck is leaving idle
                  if (!edges[0]) lead_stb  <= 1'b1;
                  else           trail_stb <= 1'b1;
                  if (edges_nx == {nbits_q, 1'b0}) begin
                     gcnt  <= '0;
                     state <= GAP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               sck <= cpol_q;
               if (gcnt == GAP_V) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_sck       = sck;
   assign bus.o_lead_stb  = lead_stb;
   assign bus.o_trail_stb = trail_stb;
   assign bus.o_busy      = busy;
   assign bus.o_done      = done;

endmodule

// File: tb/tb_sdc_clk_gen.sv
// Self-checking bench for sdc_clk_gen: default build (A) and a zero-gap build (B),
// table of bursts plus hand sequences, strobes/done/busy checked by a scoreboard.
module tb_sdc_clk_gen;

   localparam int HALF_S = 135;
   localparam int HALF_F = 14;
   localparam int GAP_A  = 540;
   localparam int GAP_B  = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   cmp_n = 0;
   int   err_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdc_clk_gen_if #(.NB_W(7)) ia ();
   sdc_clk_gen_if #(.NB_W(7)) ib ();

   sdc_clk_gen #(
      .DIV_W(10), .DIV_SLOW(HALF_S), .DIV_FAST(HALF_F), .GAP_CYC(GAP_A), .NB_W(7)
   ) dut_a (
      .i_clk_27_MHz(clk), .i_rst_n(rst_n), .bus(ia.slave)
   );

   sdc_clk_gen #(
      .DIV_W(10), .DIV_SLOW(HALF_S), .DIV_FAST(HALF_F), .GAP_CYC(GAP_B), .NB_W(7)
   ) dut_b (
      .i_clk_27_MHz(clk), .i_rst_n(rst_n), .bus(ib.slave)
   );

   // kind: 0 lead strobe, 1 trail strobe, 2 done pulse
   typedef struct {
      int   cyc;
      int   kind;
      logic sck;
   } ev_t;

   ev_t evq[2][$];
   int  blo[2] = '{0, 0};
   int  bhi[2] = '{0, 0};

   typedef struct {
      int d;
      bit fast;
      bit cpol;
      int nb;
      int exp_done;
   } row_t;

   task automatic chk(input string nm, input int got, input int want);
      cmp_n++;
      if (got !== want) begin
         err_n++;
         $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, got, want, cyc);
      end
   endtask

   task automatic mon(input int d, input logic sck, input logic lead, input logic trail,
                      input logic busy, input logic done);
      ev_t  e;
      int   kind;
      logic eb;
      eb = (cyc >= blo[d]) && (cyc < bhi[d]);
      cmp_n++;
      if (busy !== eb) begin
         err_n++;
         $display("FAIL busy%0d: got %b, want %b (cyc %0d)", d, busy, eb, cyc);
      end
      while (evq[d].size() > 0 && evq[d][0].cyc < cyc) begin
         e = evq[d].pop_front();
         cmp_n++;
         err_n++;
         $display("FAIL missing%0d: got none, want kind %0d at cyc %0d", d, e.kind, e.cyc);
      end
      if (lead && trail) begin
         cmp_n++;
         err_n++;
         $display("FAIL both_stb%0d: got lead&trail, want one (cyc %0d)", d, cyc);
      end
      if (lead || trail || done) begin
         kind = done ? 2 : (lead ? 0 : 1);
         cmp_n++;
         if (evq[d].size() == 0) begin
            err_n++;
            $display("FAIL unexpected%0d: got kind %0d at cyc %0d, want nothing", d, kind, cyc);
         end else begin
            e = evq[d].pop_front();
            if (e.cyc != cyc || e.kind != kind || (kind != 2 && sck !== e.sck)) begin
               err_n++;
               $display("FAIL event%0d: got kind %0d sck %b at cyc %0d, want kind %0d sck %b at cyc %0d",
                        d, kind, sck, cyc, e.kind, e.sck, e.cyc);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, ia.o_sck, ia.o_lead_stb, ia.o_trail_stb, ia.o_busy, ia.o_done);
      mon(1, ib.o_sck, ib.o_lead_stb, ib.o_trail_stb, ib.o_busy, ib.o_done);
   end

   task automatic drive(input int d, input bit st, input bit fast, input bit cpol, input int nb);
      if (d == 0) begin
         ia.i_start = st; ia.i_fast = fast; ia.i_cpol = cpol; ia.i_nbits = 7'(nb);
      end else begin
         ib.i_start = st; ib.i_fast = fast; ib.i_cpol = cpol; ib.i_nbits = 7'(nb);
      end
   endtask

   task automatic start_burst(input int d, input bit fast, input bit cpol, input int nb,
                              input bit sync, output int t);
      int  half;
      int  gap;
      int  e;
      ev_t ev;
      if (sync) @(negedge clk);
      drive(d, 1'b1, fast, cpol, nb);
      t = cyc + 1;
      if (nb != 0 && !((t - 1) >= blo[d] && (t - 1) < bhi[d])) begin
         half = fast ? HALF_F : HALF_S;
         gap  = (d == 0) ? GAP_A : GAP_B;
         for (int k = 1; k <= 2 * nb; k++) begin
            ev.cyc  = t + k * half;
            ev.kind = (k % 2 == 1) ? 0 : 1;
            ev.sck  = (k % 2 == 1) ? ~cpol : cpol;
            evq[d].push_back(ev);
         end
         e = t + 2 * nb * half;
         ev.cyc  = e + gap + 1;
         ev.kind = 2;
         ev.sck  = cpol;
         evq[d].push_back(ev);
         blo[d] = t;
         bhi[d] = e + gap + 1;
      end
      @(negedge clk);
      if (d == 0) ia.i_start = 1'b0;
      else        ib.i_start = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget, output bit found, output int dc);
      found = 1'b0;
      dc    = -1;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if ((d == 0) ? ia.o_done : ib.o_done) begin
            found = 1'b1;
            dc    = cyc;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   initial begin
      row_t rows[5];
      int   t;
      int   t2;
      int   dc;
      bit   f;

      rows[0] = '{d: 0, fast: 1'b0, cpol: 1'b0, nb: 8, exp_done: 2701};
      rows[1] = '{d: 0, fast: 1'b1, cpol: 1'b1, nb: 1, exp_done: 569};
      rows[2] = '{d: 1, fast: 1'b1, cpol: 1'b0, nb: 2, exp_done: 57};
      rows[3] = '{d: 1, fast: 1'b1, cpol: 1'b1, nb: 3, exp_done: 85};
      rows[4] = '{d: 0, fast: 1'b0, cpol: 1'b1, nb: 1, exp_done: 811};

      drive(0, 1'b0, 1'b0, 1'b1, 0);
      drive(1, 1'b0, 1'b0, 1'b0, 0);
      rst_n = 1'b0;

      // reset and idle tracking
      repeat (5) begin
         @(negedge clk);
         chk("rst_sck", int'(ia.o_sck), 0);
         chk("rst_done", int'(ia.o_done), 0);
         chk("rst_stb", int'(ia.o_lead_stb | ia.o_trail_stb), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_sck_after_rst", int'(ia.o_sck), 1);
      ia.i_cpol = 1'b0;
      @(negedge clk);
      chk("idle_sck_follow", int'(ia.o_sck), 0);
      chk("idle_stb", int'(ia.o_lead_stb | ia.o_trail_stb), 0);

      // table of bursts
      for (int r = 0; r < 5; r++) begin
         start_burst(rows[r].d, rows[r].fast, rows[r].cpol, rows[r].nb, 1'b1, t);
         wait_done(rows[r].d, 4000, f, dc);
         chk($sformatf("row%0d_done_ofs", r), dc - t, rows[r].exp_done);
      end

      // zero-length request is ignored
      start_burst(1, 1'b1, 1'b0, 0, 1'b1, t);
      wait_done(1, 80, f, dc);
      chk("nb0_no_done", int'(f), 0);
      chk("nb0_no_busy", int'(ib.o_busy), 0);

      // mid-burst start and rate/polarity changes have no effect
      start_burst(0, 1'b0, 1'b0, 2, 1'b1, t);
      while (cyc < t + 200) @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 5);
      @(negedge clk);
      ia.i_start = 1'b0;
      wait_done(0, 3000, f, dc);
      chk("mid_done_ofs", dc - t, 1081);
      start_burst(0, 1'b1, 1'b0, 1, 1'b0, t2);
      chk("b2b_start_cyc", t2 - dc, 1);
      wait_done(0, 1000, f, dc);
      chk("b2b_done_ofs", dc - t2, 569);

      // reset at toggle 5 of a slow burst
      start_burst(0, 1'b0, 1'b0, 8, 1'b1, t);
      while (cyc < t + 5 * HALF_S) @(negedge clk);
      chk("pre_rst_sck", int'(ia.o_sck), 1);
      #2;
      rst_n = 1'b0;
      evq[0].delete();
      blo[0] = 0;
      bhi[0] = 0;
      #1;
      chk("async_rst_sck", int'(ia.o_sck), 0);
      chk("async_rst_busy", int'(ia.o_busy), 0);
      chk("async_rst_lead", int'(ia.o_lead_stb), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_done(0, 3000, f, dc);
      chk("rst_no_done", int'(f), 0);
      start_burst(0, 1'b0, 1'b0, 8, 1'b1, t);
      wait_done(0, 4000, f, dc);
      chk("post_rst_done_ofs", dc - t, 2701);

      repeat (5) @(negedge clk);
      chk("queue_a_empty", evq[0].size(), 0);
      chk("queue_b_empty", evq[1].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
